// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bit positions,
// exception cause codes, access-size encodings and FSM state constants.
package ex_mem_pipe_pkg;

    localparam int CTL_W      = 6;
    localparam int CTL_BRANCH = 5;
    localparam int CTL_JAL    = 4;
    localparam int CTL_JALR   = 3;
    localparam int CTL_LOAD   = 2;
    localparam int CTL_STORE  = 1;
    localparam int CTL_REGWR  = 0;

    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    // funct3[1:0] gives the access size; the undefined size 2'b11 never traps here.
    function automatic logic f_mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = (addr_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_align_check.sv
// Combinational control-transfer resolution and alignment checking for one
// EX beat: taken decision, exception flag and cause.
module ex_align_check
    import ex_mem_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]  i_target,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [2:0]       i_funct3,
    input  logic [CTL_W-1:0] i_ctl,
    input  logic             i_branch,
    output logic             o_taken,
    output logic             o_exc,
    output logic [3:0]       o_cause
);
    logic w_mem_mis;
    logic w_unused;

    assign o_taken   = i_ctl[CTL_JAL] || i_ctl[CTL_JALR] || (i_ctl[CTL_BRANCH] && i_branch);
    assign w_mem_mis = f_mem_misaligned(i_funct3[1:0], i_addr[1:0]);
    assign w_unused  = ^{i_target[XLEN-1:2], i_target[0], i_addr[XLEN-1:2], i_funct3[2], i_ctl[CTL_REGWR]};

    // Target misalignment only matters when the transfer is actually taken.
    always_comb begin
        o_exc   = 1'b0;
        o_cause = CAUSE_IMISALIGN;
        if (o_taken && i_target[1]) begin
            o_exc   = 1'b1;
            o_cause = CAUSE_IMISALIGN;
        end else if (i_ctl[CTL_LOAD] && w_mem_mis) begin
            o_exc   = 1'b1;
            o_cause = CAUSE_LMISALIGN;
        end else if (i_ctl[CTL_STORE] && w_mem_mis) begin
            o_exc   = 1'b1;
            o_cause = CAUSE_SMISALIGN;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: single-entry valid/ready stage that resolves
// branches/jumps into a one-cycle redirect and squashes wrong-path beats.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic             in_branch,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [CTL_W-1:0] in_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_addr,
    output logic [XLEN-1:0]  out_wdata,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic             out_reg_write,
    output logic             out_exc,
    output logic [3:0]       out_cause,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);
    localparam logic [2:0] LP_FLUSH = 3'(FLUSH_DEPTH);

    logic [0:0]      r_state;
    logic [2:0]      r_squash_cnt;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic            r_reg_write;
    logic            r_exc;
    logic [3:0]      r_cause;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_taken;
    logic            w_exc;
    logic [3:0]      w_cause;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_discard;
    logic            w_redirect;

    assign w_target = in_ctl[CTL_JALR] ? {in_alu_out[XLEN-1:1], 1'b0} : (in_pc + in_imm);
    assign w_link   = in_pc + XLEN'(4);

    ex_align_check #(.XLEN(XLEN)) u_align (
        .i_target (w_target),
        .i_addr   (in_alu_out),
        .i_funct3 (in_funct3),
        .i_ctl    (in_ctl),
        .i_branch (in_branch),
        .o_taken  (w_taken),
        .o_exc    (w_exc),
        .o_cause  (w_cause)
    );

    // While squashing, wrong-path beats are swallowed without touching the held beat.
    assign w_in_ready = (r_state == ST_SQUASH) || !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && (r_state == ST_RUN);
    assign w_discard  = in_valid && (r_state == ST_SQUASH);
    assign w_redirect = w_accept && w_taken && !w_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_squash_cnt     <= 3'd0;
            r_out_valid      <= 1'b0;
            r_result         <= '0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_rd             <= '0;
            r_funct3         <= '0;
            r_mem_rd         <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_reg_write      <= 1'b0;
            r_exc            <= 1'b0;
            r_cause          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect;

            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_result      <= (in_ctl[CTL_JAL] || in_ctl[CTL_JALR]) ? w_link : in_alu_out;
                r_addr        <= in_alu_out;
                r_wdata       <= in_rs2;
                r_rd          <= in_rd;
                r_funct3      <= in_funct3;
                r_mem_rd      <= in_ctl[CTL_LOAD] && !w_exc;
                r_mem_wr      <= in_ctl[CTL_STORE] && !w_exc;
                r_reg_write   <= in_ctl[CTL_REGWR] && !w_exc;
                r_exc         <= w_exc;
                r_cause       <= w_cause;
                r_redirect_pc <= w_target;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_state == ST_RUN) begin
                if (w_redirect && (LP_FLUSH != 3'd0)) begin
                    r_state      <= ST_SQUASH;
                    r_squash_cnt <= LP_FLUSH;
                end
            end else if (w_discard) begin
                r_squash_cnt <= r_squash_cnt - 3'd1;
                if (r_squash_cnt == 3'd1) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign in_ready       = rst_n && w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_result     = r_result;
    assign out_addr       = r_addr;
    assign out_wdata      = r_wdata;
    assign out_rd         = r_rd;
    assign out_funct3     = r_funct3;
    assign out_mem_rd     = r_mem_rd;
    assign out_mem_wr     = r_mem_wr;
    assign out_reg_write  = r_reg_write;
    assign out_exc        = r_exc;
    assign out_cause      = r_cause;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_ex_mem_pipe;
    localparam int XLEN = 32;
    localparam int FD   = 2;
    localparam int NV   = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, in_ready, in_branch, out_valid, out_ready;
    logic [XLEN-1:0]  in_pc, in_alu_out, in_imm, in_rs2;
    logic [4:0]       in_rd, out_rd;
    logic [2:0]       in_funct3, out_funct3;
    logic [5:0]       in_ctl;
    logic [XLEN-1:0]  out_result, out_addr, out_wdata, redirect_pc;
    logic             out_mem_rd, out_mem_wr, out_reg_write, out_exc, redirect_valid;
    logic [3:0]       out_cause;

    ex_mem_pipe #(.XLEN(XLEN), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu_out(in_alu_out),
        .in_branch(in_branch), .in_imm(in_imm), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_ctl(in_ctl),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_reg_write(out_reg_write),
        .out_exc(out_exc), .out_cause(out_cause),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, alu, imm, rs2;
        logic        br;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [5:0]  ctl;   // {branch, jal, jalr, load, store, reg_write}
        logic        ordy;
    } in_t;

    typedef struct {
        logic [31:0] result, addr, wdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mrd, mwr, rw, exc;
        logic [3:0]  cause;
    } out_t;

    typedef struct {
        in_t         in;
        logic [31:0] e_res;
        logic        e_mrd, e_mwr, e_rw, e_exc;
        logic [3:0]  e_cause;
        logic        e_redir, e_chk_tgt;
        logic [31:0] e_tgt;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NV];

    // Transaction-level model state
    logic        m_held_valid;
    out_t        m_held;
    int          m_squash;
    logic        m_redir;
    logic [31:0] m_redir_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_beat(input in_t b, output out_t o, output logic redir, output logic [31:0] tgt);
        logic taken, mis;
        int   size;
        taken = b.ctl[4] || b.ctl[3] || (b.ctl[5] && b.br);
        tgt   = b.ctl[3] ? (b.alu & 32'hFFFF_FFFE) : (b.pc + b.imm);
        size  = int'(b.f3[1:0]);
        mis   = (size == 1 && (b.alu % 2) != 0) || (size == 2 && (b.alu % 4) != 0);
        o.exc   = 1'b0;
        o.cause = 4'd0;
        if (taken && (tgt % 4) >= 2) begin
            o.exc = 1'b1; o.cause = 4'd0;
        end else if (b.ctl[2] && mis) begin
            o.exc = 1'b1; o.cause = 4'd4;
        end else if (b.ctl[1] && mis) begin
            o.exc = 1'b1; o.cause = 4'd6;
        end
        o.result = (b.ctl[4] || b.ctl[3]) ? b.pc + 32'd4 : b.alu;
        o.addr   = b.alu;
        o.wdata  = b.rs2;
        o.rd     = b.rd;
        o.f3     = b.f3;
        o.mrd    = b.ctl[2] && !o.exc;
        o.mwr    = b.ctl[1] && !o.exc;
        o.rw     = b.ctl[0] && !o.exc;
        redir    = taken && !o.exc;
    endfunction

    task automatic drive(input in_t s);
        in_valid   = s.valid;
        in_pc      = s.pc;
        in_alu_out = s.alu;
        in_imm     = s.imm;
        in_rs2     = s.rs2;
        in_branch  = s.br;
        in_rd      = s.rd;
        in_funct3  = s.f3;
        in_ctl     = s.ctl;
        out_ready  = s.ordy;
    endtask

    task automatic cmp_outputs();
        chk("out_valid", out_valid, m_held_valid);
        chk("redirect_valid", redirect_valid, m_redir);
        if (m_redir) chk("redirect_pc", redirect_pc, m_redir_pc);
        if (m_held_valid) begin
            chk("out_result", out_result, m_held.result);
            chk("out_addr", out_addr, m_held.addr);
            chk("out_wdata", out_wdata, m_held.wdata);
            chk("out_rd", out_rd, m_held.rd);
            chk("out_funct3", out_funct3, m_held.f3);
            chk("out_mem_rd", out_mem_rd, m_held.mrd);
            chk("out_mem_wr", out_mem_wr, m_held.mwr);
            chk("out_reg_write", out_reg_write, m_held.rw);
            chk("out_exc", out_exc, m_held.exc);
            chk("out_cause", out_cause, m_held.cause);
        end
    endtask

    // One clock: drive at posedge+1, check in_ready, step, update model, compare.
    task automatic cycle(input in_t s);
        logic        exp_rdy, r;
        out_t        o;
        logic [31:0] t;
        drive(s);
        #1;
        exp_rdy = (m_squash > 0) || !m_held_valid || s.ordy;
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        m_redir = 1'b0;
        if (m_squash > 0) begin
            if (s.valid) m_squash--;
            if (s.ordy) m_held_valid = 1'b0;
        end else if (s.valid && exp_rdy) begin
            model_beat(s, o, r, t);
            m_held_valid = 1'b1;
            m_held       = o;
            if (r) begin
                m_redir    = 1'b1;
                m_redir_pc = t;
                m_squash   = FD;
            end
        end else if (s.ordy) begin
            m_held_valid = 1'b0;
        end
        #1;
        cmp_outputs();
    endtask

    // Asserts reset away from any clock edge, so zeros seen here prove it is asynchronous.
    task automatic do_reset();
        in_t z;
        z = '{default: '0};
        rst_n = 1'b0;
        drive(z);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_wdata", out_wdata, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_funct3", out_funct3, 0);
        chk("rst_out_mem_rd", out_mem_rd, 0);
        chk("rst_out_mem_wr", out_mem_wr, 0);
        chk("rst_out_reg_write", out_reg_write, 0);
        chk("rst_out_exc", out_exc, 0);
        chk("rst_out_cause", out_cause, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        m_held_valid = 1'b0;
        m_squash     = 0;
        m_redir      = 1'b0;
    endtask

    task automatic setv(input int i, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                        input logic [31:0] rs2, input logic br, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [5:0] ctl, input logic [31:0] e_res, input logic e_mrd, input logic e_mwr,
                        input logic e_rw, input logic e_exc, input logic [3:0] e_cause, input logic e_redir,
                        input logic e_chk, input logic [31:0] e_tgt);
        vecs[i].in        = '{default: '0};
        vecs[i].in.valid  = 1'b1;
        vecs[i].in.ordy   = 1'b1;
        vecs[i].in.pc     = pc;
        vecs[i].in.alu    = alu;
        vecs[i].in.imm    = imm;
        vecs[i].in.rs2    = rs2;
        vecs[i].in.br     = br;
        vecs[i].in.rd     = rd;
        vecs[i].in.f3     = f3;
        vecs[i].in.ctl    = ctl;
        vecs[i].e_res     = e_res;
        vecs[i].e_mrd     = e_mrd;
        vecs[i].e_mwr     = e_mwr;
        vecs[i].e_rw      = e_rw;
        vecs[i].e_exc     = e_exc;
        vecs[i].e_cause   = e_cause;
        vecs[i].e_redir   = e_redir;
        vecs[i].e_chk_tgt = e_chk;
        vecs[i].e_tgt     = e_tgt;
    endtask

    function automatic in_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                               input logic br, input logic [4:0] rd, input logic [5:0] ctl, input logic ordy);
        in_t s;
        s       = '{default: '0};
        s.valid = 1'b1;
        s.pc    = pc;
        s.alu   = alu;
        s.imm   = imm;
        s.br    = br;
        s.rd    = rd;
        s.f3    = 3'b010;
        s.ctl   = ctl;
        s.ordy  = ordy;
        return s;
    endfunction

    function automatic in_t rand_beat();
        in_t s;
        s       = '{default: '0};
        s.pc    = $urandom & 32'hFFFF_FFFC;
        s.alu   = $urandom;
        s.imm   = $urandom_range(63) - 32'd32;
        s.rs2   = $urandom;
        s.br    = 1'($urandom_range(1));
        s.rd    = 5'($urandom);
        s.f3    = 3'($urandom);
        case ($urandom_range(5))
            0: s.ctl = 6'b000001;   // ALU op
            1: s.ctl = 6'b100000;   // branch
            2: s.ctl = 6'b010001;   // jal
            3: s.ctl = 6'b001001;   // jalr
            4: s.ctl = 6'b000101;   // load
            default: s.ctl = 6'b000010; // store
        endcase
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  s, a, b;
        logic have, rdy_pred;
        logic [31:0] held_res;

        rst_n = 1'b0;
        m_held_valid = 1'b0; m_squash = 0; m_redir = 1'b0; m_redir_pc = '0;
        m_held = '{default: '0};

        //     i   pc       alu          imm      rs2          br rd f3      ctl        res          mrd mwr rw exc cause redir chk tgt
        setv(0,  32'h0,   32'h10,      32'h0,   32'h0,        0, 5, 3'b000, 6'b000001, 32'h10,      0, 0, 1, 0, 4'd0, 0, 0, 32'h0);
        setv(1,  32'h40,  32'h0,       32'h10,  32'h0,        0, 1, 3'b000, 6'b010001, 32'h44,      0, 0, 1, 0, 4'd0, 1, 1, 32'h50);
        setv(2,  32'h40,  32'h203,     32'h0,   32'h0,        0, 1, 3'b000, 6'b001001, 32'h44,      0, 0, 0, 1, 4'd0, 0, 1, 32'h202);
        setv(3,  32'h0,   32'h1002,    32'h0,   32'hDEADBEEF, 0, 0, 3'b010, 6'b000010, 32'h1002,    0, 0, 0, 1, 4'd6, 0, 0, 32'h0);
        setv(4,  32'h0,   32'h1003,    32'h0,   32'h0,        0, 7, 3'b001, 6'b000101, 32'h1003,    0, 0, 0, 1, 4'd4, 0, 0, 32'h0);
        setv(5,  32'h0,   32'h1003,    32'h0,   32'h0,        0, 7, 3'b000, 6'b000101, 32'h1003,    1, 0, 1, 0, 4'd0, 0, 0, 32'h0);
        setv(6,  32'h0,   32'h1004,    32'h0,   32'h12345678, 0, 0, 3'b010, 6'b000010, 32'h1004,    0, 1, 0, 0, 4'd0, 0, 0, 32'h0);
        setv(7,  32'h100, 32'h1,       32'h22,  32'h0,        0, 0, 3'b000, 6'b100000, 32'h1,       0, 0, 0, 0, 4'd0, 0, 0, 32'h0);
        setv(8,  32'h0,   32'h1002,    32'h0,   32'h0,        0, 9, 3'b010, 6'b000101, 32'h1002,    0, 0, 0, 1, 4'd4, 0, 0, 32'h0);
        setv(9,  32'h0,   32'h1001,    32'h0,   32'h0,        0, 0, 3'b001, 6'b000010, 32'h1001,    0, 0, 0, 1, 4'd6, 0, 0, 32'h0);
        setv(10, 32'h100, 32'h0,       32'h6,   32'h0,        1, 0, 3'b001, 6'b100000, 32'h0,       0, 0, 0, 1, 4'd0, 0, 1, 32'h106);
        setv(11, 32'h80,  32'h301,     32'h0,   32'h0,        0, 1, 3'b000, 6'b001001, 32'h84,      0, 0, 1, 0, 4'd0, 1, 1, 32'h300);
        setv(12, 32'h0,   32'h1002,    32'h0,   32'h0,        0, 3, 3'b101, 6'b000101, 32'h1002,    1, 0, 1, 0, 4'd0, 0, 0, 32'h0);

        // Directed vector table, each from a fresh reset
        for (int i = 0; i < NV; i++) begin
            do_reset();
            cycle(vecs[i].in);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].e_res);
            chk($sformatf("v%0d_addr", i), out_addr, vecs[i].in.alu);
            chk($sformatf("v%0d_wdata", i), out_wdata, vecs[i].in.rs2);
            chk($sformatf("v%0d_rd", i), out_rd, vecs[i].in.rd);
            chk($sformatf("v%0d_mem_rd", i), out_mem_rd, vecs[i].e_mrd);
            chk($sformatf("v%0d_mem_wr", i), out_mem_wr, vecs[i].e_mwr);
            chk($sformatf("v%0d_reg_write", i), out_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d_exc", i), out_exc, vecs[i].e_exc);
            chk($sformatf("v%0d_cause", i), out_cause, vecs[i].e_cause);
            chk($sformatf("v%0d_redirect", i), redirect_valid, vecs[i].e_redir);
            if (vecs[i].e_chk_tgt) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_tgt);
            $display("vec %0d ctl=%b alu=%h -> valid=%0d result=%h exc=%0d cause=%0d redir=%0d rpc=%h",
                     i, vecs[i].in.ctl, vecs[i].in.alu, out_valid, out_result, out_exc, out_cause,
                     redirect_valid, redirect_pc);
        end

        // Taken beq then three back-to-back beats: two squashed, third passes
        do_reset();
        cycle(mk(32'h100, 32'h0, 32'h20, 1'b1, 5'd0, 6'b100000, 1'b1));
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_out_valid", out_valid, 1);
        cycle(mk(32'h104, 32'hA1, 32'h0, 1'b0, 5'd1, 6'b000001, 1'b1));
        chk("sq1_out_valid", out_valid, 0);
        chk("sq1_redirect", redirect_valid, 0);
        cycle(mk(32'h108, 32'h0, 32'h40, 1'b1, 5'd2, 6'b100000, 1'b1));
        chk("sq2_out_valid", out_valid, 0);
        chk("sq2_redirect", redirect_valid, 0);
        cycle(mk(32'h10C, 32'hA3, 32'h0, 1'b0, 5'd3, 6'b000001, 1'b1));
        chk("post_sq_valid", out_valid, 1);
        chk("post_sq_rd", out_rd, 3);
        chk("post_sq_result", out_result, 32'hA3);
        $display("beq squash sequence: valid=%0d rd=%0d", out_valid, out_rd);

        // Backpressure: held beat stays stable, then drain and accept in one cycle
        do_reset();
        a = mk(32'h200, 32'h55, 32'h0, 1'b0, 5'd4, 6'b000001, 1'b1);
        cycle(a);
        held_res = out_result;
        b = mk(32'h204, 32'h66, 32'h0, 1'b0, 5'd6, 6'b000001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(b);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            chk($sformatf("bp%0d_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_result", k), out_result, 32'h55);
            chk($sformatf("bp%0d_rd", k), out_rd, 4);
        end
        b.ordy = 1'b1;
        cycle(b);
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_result", out_result, 32'h66);
        chk("bp_release_rd", out_rd, 6);
        $display("backpressure: held result %h, then result %h", held_res, out_result);

        // Reset in the middle of SQUASH with a held beat
        do_reset();
        cycle(mk(32'h40, 32'h0, 32'h10, 1'b0, 5'd1, 6'b010001, 1'b0));
        cycle(mk(32'h44, 32'h77, 32'h0, 1'b0, 5'd2, 6'b000001, 1'b0));
        chk("midsq_held_valid", out_valid, 1);
        do_reset();
        cycle(mk(32'h300, 32'h99, 32'h0, 1'b0, 5'd8, 6'b000001, 1'b1));
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_result", out_result, 32'h99);
        chk("after_rst_redirect", redirect_valid, 0);
        $display("reset mid-squash: next beat valid=%0d result=%h", out_valid, out_result);

        // Randomized traffic against the model, holding unaccepted beats
        do_reset();
        have = 1'b0;
        s = '{default: '0};
        for (int i = 0; i < 600; i++) begin
            if (!have) begin
                s = rand_beat();
                s.valid = ($urandom_range(3) != 0);
            end
            s.ordy = ($urandom_range(3) != 0);
            rdy_pred = (m_squash > 0) || !m_held_valid || s.ordy;
            cycle(s);
            have = s.valid && !rdy_pred;
            if (i % 50 == 0)
                $display("rand %0d: ctl=%b valid=%0d out_valid=%0d redir=%0d", i, s.ctl, s.valid, out_valid, redirect_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU core in the five-stage RV32I pipeline.
- Captures the ALU result and branch predicate together with instruction control bits into the EX/MEM register.
- Resolves branches and jumps into a redirect pulse, then squashes a fixed number of wrong-path beats.
- Flags misaligned jump targets and misaligned load/store addresses. Applies valid/ready backpressure toward the memory stage.

Parameters:
- XLEN, 32, datapath width.
- FLUSH_DEPTH, 2, number of younger in_valid beats discarded after a redirect (range 0..7).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX beat valid
- in_ready  out  1  stage can accept a beat
- in_pc  in  XLEN  instruction PC
- in_alu_out  in  XLEN  ALU result; this is the address for load, store and jalr
- in_branch  in  1  ALU branch predicate
- in_imm  in  XLEN  sign-extended immediate
- in_rs2  in  XLEN  store data
- in_rd  in  5  destination register
- in_funct3  in  3  funct3 field
- in_ctl  in  6  {is_branch, is_jal, is_jalr, is_load, is_store, reg_write}
- out_valid  out  1  EX/MEM beat valid
- out_ready  in  1  memory stage accepts
- out_result  out  XLEN  writeback value: pc+4 for jal/jalr, otherwise alu_out
- out_addr  out  XLEN  memory address (alu_out)
- out_wdata  out  XLEN  store data
- out_rd  out  5
- out_funct3  out  3
- out_mem_rd  out  1  load enable
- out_mem_wr  out  1  store enable
- out_reg_write  out  1
- out_exc  out  1  exception flag
- out_cause  out  4  exception cause
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs are 0.
  - State goes to RUN and squash_cnt to 0.
  - Any held beat is dropped.
- Storage is a single-entry register.
  - in_ready = !out_valid || out_ready.
  - A beat is accepted on in_valid && in_ready.
  - out_valid rises the cycle after acceptance. It holds, with all out_* stable, until out_ready.
  - Simultaneous drain and accept in one cycle is permitted, so full throughput is one beat per cycle.
  - Latency is one cycle.
- Control transfer is taken when is_jal, or is_jalr, or (is_branch && in_branch).
- Target computation:
  - Branch and jal: target = in_pc + in_imm, modulo 2^XLEN.
  - jalr: target = in_alu_out with bit 0 cleared.
- Target misalignment:
  - If a taken target has bit 1 set: out_exc=1, cause 0, no redirect, reg_write forced to 0.
  - A not-taken branch never raises this exception.
- Memory alignment:
  - funct3[1:0]: 00 byte, never misaligned; 01 half, misaligned if addr[0]; 10 word, misaligned if addr[1:0] != 0.
  - A misaligned load gives cause 4. A misaligned store gives cause 6.
  - On either, out_exc=1 and out_mem_rd, out_mem_wr and out_reg_write are all 0.
- Redirect:
  - A valid taken, non-excepting transfer asserts redirect_valid for exactly one cycle, the cycle after acceptance.
  - redirect_pc = target in that same cycle.
  - redirect_valid is not held under backpressure.
- State machine RUN/SQUASH:
  - RUN to SQUASH on redirect issue, with squash_cnt = FLUSH_DEPTH. With FLUSH_DEPTH = 0, stay in RUN.
  - In SQUASH, in_ready = 1 regardless of out_ready.
  - Each in_valid beat in SQUASH is consumed, discarded and decrements squash_cnt. Cycles without in_valid do not decrement.
  - Discarded beats never produce out_valid, redirect or exception, including taken branches.
  - At squash_cnt reaching 0, return to RUN. The next beat is processed normally.
  - The held output beat still drains normally during SQUASH.
- An exception beat does not enter SQUASH; the trap logic downstream owns the flush.
- Reset asserted mid-SQUASH or with a held beat: return to reset state immediately, with no redirect emitted.

Decomposition:
- Shared defines header holds:
  - control-bit indices of in_ctl
  - the cause codes: CAUSE_IMISALIGN=0, CAUSE_LMISALIGN=4, CAUSE_SMISALIGN=6
  - funct3 size encodings
- One natural sub-module: ex_align_check. It is combinational: given target, addr, funct3 and ctl, it returns exc and cause.

Test Plan:
- Reset then an add beat with alu_out=0x0000_0010, rd=5, reg_write=1, out_ready=1 -> out_valid next cycle, out_result=0x10, out_rd=5, no redirect.
- beq at pc=0x100, imm=0x20, in_branch=1, followed by 3 back-to-back beats, FLUSH_DEPTH=2 -> redirect_valid pulse with redirect_pc=0x120; next 2 beats discarded; 3rd beat appears on out_valid.
- jalr with alu_out=0x0000_0203, pc=0x40 -> redirect_pc=0x202, out_exc=1, cause 0, no redirect.
- jal with pc=0x40, imm=0x10 -> redirect_pc=0x50, out_result=0x44, out_reg_write=1.
- sw at addr 0x1002 -> out_exc=1, cause 6, out_mem_wr=0. lh at addr 0x1003 -> cause 4. lb at 0x1003 -> no exception, out_mem_rd=1.
- out_ready held low 3 cycles with a beat stored -> in_ready=0 and outputs stable; then release with a new in_valid -> drain and accept in the same cycle. Separately, assert rst_n low mid-SQUASH -> all outputs 0 and the next beat is processed normally.
